// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB destination/control fields.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_use_rs_q, ex_use_rs_d;
  logic              ex_use_rt_q, ex_use_rt_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_memread_q, ex_memread_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              mem_regwrite_q, mem_regwrite_d;
  logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic bubble;
  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic mem_valid, wb_valid;

  // Register 0 is hard-wired, so a write to it never produces a forwardable value.
  assign mem_valid = mem_regwrite_q && (mem_dest_q != '0);
  assign wb_valid  = wb_regwrite_q && (wb_dest_q != '0);

  assign mem_hit_a = ex_use_rs_q && mem_valid && (mem_dest_q == ex_rs_q);
  assign wb_hit_a  = ex_use_rs_q && wb_valid  && (wb_dest_q  == ex_rs_q);
  assign mem_hit_b = ex_use_rt_q && mem_valid && (mem_dest_q == ex_rt_q);
  assign wb_hit_b  = ex_use_rt_q && wb_valid  && (wb_dest_q  == ex_rt_q);

  assign fwd_a_o = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
  assign fwd_b_o = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

  assign stall_o = ex_memread_q && (ex_dest_q != '0) && !flush_i &&
                   ((id_use_rs_i && (ex_dest_q == id_rs_i)) ||
                    (id_use_rt_i && (ex_dest_q == id_rt_i)));

  assign stall_cnt_o = stall_cnt_q;
  assign bubble      = stall_o || flush_i;

  always_comb begin
    ex_rs_d        = bubble ? '0 : id_rs_i;
    ex_rt_d        = bubble ? '0 : id_rt_i;
    ex_dest_d      = bubble ? '0 : id_dest_i;
    ex_use_rs_d    = bubble ? 1'b0 : id_use_rs_i;
    ex_use_rt_d    = bubble ? 1'b0 : id_use_rt_i;
    ex_regwrite_d  = bubble ? 1'b0 : id_regwrite_i;
    ex_memread_d   = bubble ? 1'b0 : id_memread_i;
    mem_dest_d     = ex_dest_q;
    mem_regwrite_d = ex_regwrite_q;
    wb_dest_d      = mem_dest_q;
    wb_regwrite_d  = mem_regwrite_q;
    stall_cnt_d    = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dest_q      <= '0;
      ex_use_rs_q    <= 1'b0;
      ex_use_rt_q    <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      ex_use_rs_q    <= ex_use_rs_d;
      ex_use_rt_q    <= ex_use_rt_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a cycle table of ID fields with expected selects/stall,
// plus hand-written reset and counter-saturation sequences.
module tb_fwd_hazard_unit;

  typedef struct {
    logic [4:0] rs, rt, dest;
    logic       urs, urt, rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
  } vec_t;

  typedef struct {
    logic [1:0] ea, eb;
    logic       es;
    int         cnt, cnt_s;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_rw, id_mr, id_urs, id_urt, flush;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        stall, stall_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_exp = 0;
  int   cnt_s_exp = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dest_i(id_dest),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr),
    .id_use_rs_i(id_urs), .id_use_rt_i(id_urt), .flush_i(flush),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(cnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dest_i(id_dest),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr),
    .id_use_rs_i(id_urs), .id_use_rt_i(id_urt), .flush_i(flush),
    .fwd_a_o(fwd_a_s), .fwd_b_o(fwd_b_s), .stall_o(stall_s), .stall_cnt_o(cnt_s)
  );

  function automatic vec_t mk(input int rs, input int rt, input int dest,
                              input int urs, input int urt, input int rw,
                              input int mr, input int fl,
                              input int ea, input int eb, input int es);
    vec_t v;
    v.rs = rs[4:0]; v.rt = rt[4:0]; v.dest = dest[4:0];
    v.urs = urs[0]; v.urt = urt[0]; v.rw = rw[0]; v.mr = mr[0]; v.fl = fl[0];
    v.ea = ea[1:0]; v.eb = eb[1:0]; v.es = es[0];
    return v;
  endfunction

  function automatic vec_t nop(input int ea, input int eb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one ID slot, queue its expectation, and compare at the following negedge.
  task automatic drive_check(input vec_t v, input string tag);
    exp_t e;
    id_rs = v.rs; id_rt = v.rt; id_dest = v.dest;
    id_urs = v.urs; id_urt = v.urt; id_rw = v.rw; id_mr = v.mr; flush = v.fl;
    sb.push_back('{ea: v.ea, eb: v.eb, es: v.es, cnt: cnt_exp, cnt_s: cnt_s_exp, tag: tag});
    if (v.es) begin
      cnt_exp++;
      if (cnt_s_exp < 15) cnt_s_exp++;
    end
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_fwd_a"}, 32'(fwd_a), 32'(e.ea));
    check({e.tag, "_fwd_b"}, 32'(fwd_b), 32'(e.eb));
    check({e.tag, "_stall"}, 32'(stall), 32'(e.es));
    check({e.tag, "_cnt"},   32'(cnt),   32'(e.cnt));
    check({e.tag, "_cnt4"},  32'(cnt_s), 32'(e.cnt_s));
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive_check(v, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rs, rt, dest, use_rs, use_rt, regwrite, memread, flush | fwd_a, fwd_b, stall
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0));   // 0 add r3
    tbl.push_back(mk(3, 4, 6, 1, 1, 1, 0, 0, 0, 0, 0));   // 1 sub reads r3
    tbl.push_back(nop(2, 0));                            // 2 EX/MEM forward on A
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0));   // 4 add r3
    tbl.push_back(mk(7, 8, 3, 1, 1, 1, 0, 0, 0, 0, 0));   // 5 add r3 again
    tbl.push_back(mk(9, 3, 10, 1, 1, 1, 0, 0, 0, 0, 0));  // 6 or reads rt=3
    tbl.push_back(nop(0, 2));                            // 7 newest wins on B
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0));  // 9 writer r12
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(12, 12, 13, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop(1, 1));                            // 12 MEM/WB forward both
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0));   // 14 lw r5
    tbl.push_back(mk(6, 5, 7, 1, 1, 1, 0, 0, 0, 0, 1));   // 15 load-use on rt
    tbl.push_back(mk(6, 5, 7, 1, 1, 1, 0, 0, 0, 0, 0));   // 16 held, ex is bubble
    tbl.push_back(nop(0, 1));                            // 17 load via MEM/WB
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(2, 0, 8, 1, 0, 1, 1, 0, 0, 0, 0));   // 19 lw r8
    tbl.push_back(mk(8, 9, 11, 1, 1, 1, 0, 0, 0, 0, 1));  // 20 load-use on rs
    tbl.push_back(mk(8, 9, 11, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop(1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0));   // 23 lw r4
    tbl.push_back(mk(4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // 24 fields match, unused
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));   // 26 lw r0
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));   // 27 reader of r0, no stall
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));   // 28 r0 in mem not forwarded
    tbl.push_back(nop(0, 0));                            // 29 r0 in wb not forwarded
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0, 0));   // 31 lw r9
    tbl.push_back(mk(9, 2, 15, 1, 1, 1, 0, 1, 0, 0, 0));  // 32 dependent but flushed
    tbl.push_back(mk(9, 9, 16, 1, 1, 1, 0, 0, 0, 0, 0));  // 33 ex holds bubble
    tbl.push_back(nop(1, 1));
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 2, 20, 1, 1, 1, 0, 0, 0, 0, 0));  // 36 add r20
    tbl.push_back(mk(3, 4, 20, 1, 1, 1, 0, 0, 0, 0, 0));  // 37 add r20 again
    tbl.push_back(mk(20, 21, 22, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop(2, 0));                            // 39 newest wins on A
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(1, 0, 23, 1, 0, 1, 1, 0, 0, 0, 0));  // 41 lw r23
    tbl.push_back(nop(0, 0));
    tbl.push_back(mk(0, 23, 24, 0, 1, 1, 0, 0, 0, 0, 0)); // 43 one slot later, no stall
    tbl.push_back(nop(0, 1));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));

    rst = 1'b1;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_rw = 1'b0; id_mr = 1'b0; id_urs = 1'b0; id_urt = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("init_fwd_a", 32'(fwd_a), 0);
    check("init_fwd_b", 32'(fwd_b), 0);
    check("init_stall", 32'(stall), 0);
    check("init_cnt",   32'(cnt),   0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle while a load-use stall and an EX/MEM forward are active.
    apply(mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0), "rst_add");
    apply(mk(3, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0), "rst_lw");
    drive_check(mk(0, 5, 6, 0, 1, 1, 0, 0, 2, 0, 1), "rst_pre");
    #2 rst = 1'b0;
    #1;
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_fwd_b", 32'(fwd_b), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_cnt",   32'(cnt),   0);
    check("rst_cnt4",  32'(cnt_s), 0);
    cnt_exp = 0;
    cnt_s_exp = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) apply(nop(0, 0), $sformatf("post_rst_nop%0d", i));

    // 17 load-use stalls: 4-bit counter must stop at 15, 16-bit one reaches 17.
    for (int k = 0; k < 17; k++) begin
      apply(mk(0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0), $sformatf("sat%0d_lw", k));
      apply(mk(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("sat%0d_stall", k));
      apply(mk(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0), $sformatf("sat%0d_held", k));
      apply(nop(0, 1), $sformatf("sat%0d_fwd", k));
    end
    @(negedge clk);
    check("sat_cnt4_final", 32'(cnt_s), 15);
    check("sat_cnt16_final", 32'(cnt), 17);
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
